z80_bus_responder: RTL and testbench
====================================

// Module: z80_bus_responder
// PURPOSE
//  Synthesizable Z80 bus target for the tv80 core under test: owns byte memory, answers
//  memory/IO/interrupt-acknowledge cycles and inserts wait states on wait_n. Replaces the
//  bench-side memory array so the CPU-level tests run against a real bus responder.
//  A preload port fills memory before reset release, in place of direct mem[] pokes.
// PARAMETERS
//  MEM_AW       16     memory address width; memory depth = 2**MEM_AW bytes, addr[MEM_AW-1:0] used
//  WAIT_STATES  0      wait cycles per memory/IO access (0..15)
//  INTA_WAITS   2      wait cycles for interrupt acknowledge (0..15)
// PORTS
//  i_clk          in   1   clock; all state changes on rising edge
//  i_reset_n      in   1   asynchronous, active-low reset
//  i_a            in   16  CPU address bus
//  i_do           in   8   CPU data out (write data)
//  i_mreq_n       in   1   memory request strobe
//  i_iorq_n       in   1   IO request strobe
//  i_rd_n         in   1   read strobe
//  i_wr_n         in   1   write strobe
//  i_m1_n         in   1   opcode fetch / INTA marker
//  i_rfsh_n       in   1   refresh marker
//  o_di           out  8   data to CPU
//  o_wait_n       out  1   wait request to CPU (0 = stretch cycle)
//  i_io_rdata     in   8   byte returned for IO reads
//  i_int_vector   in   8   byte returned during interrupt acknowledge
//  o_io_wr        out  1   one-cycle pulse: IO write accepted
//  o_io_addr      out  8   IO port (i_a[7:0]) of last IO write
//  o_io_data      out  8   data of last IO write
//  i_ld_en        in   1   preload write strobe
//  i_ld_addr      in   16  preload address
//  i_ld_data      in   8   preload data
//  o_busy         out  1   1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: o_di=8'h00, o_wait_n=1, o_io_wr=0, o_io_addr=0, o_io_data=0, o_busy=0, FSM=IDLE.
//   Memory contents are NOT cleared by reset. Reset mid-cycle aborts: no write commits.
//  Cycle decode (sampled each rising edge in IDLE):
//   MRD  = !mreq_n & !rd_n & rfsh_n     MWR = !mreq_n & !wr_n & rfsh_n
//   IORD = !iorq_n & !rd_n & m1_n       IOWR = !iorq_n & !wr_n & m1_n
//   INTA = !iorq_n & !m1_n              refresh (!mreq_n & !rfsh_n): ignored, wait_n stays 1
//   Priority if several true: INTA > MWR > MRD > IOWR > IORD.
//  FSM: IDLE -> WAIT (count=N) if N>0, else -> ACCESS; N = INTA_WAITS for INTA else WAIT_STATES.
//   WAIT: o_wait_n=0 (registered, goes low the cycle after decode); count decrements each
//    cycle; at count==1 -> ACCESS. If strobes deassert while in WAIT -> IDLE, no commit.
//   ACCESS: one cycle; reads load o_di (mem[a], i_io_rdata or i_int_vector); MWR writes
//    mem[a[MEM_AW-1:0]]=i_do; IOWR pulses o_io_wr and latches o_io_addr/o_io_data.
//    o_wait_n=1. -> HOLD.
//   HOLD: o_di held; stay until all of mreq_n, iorq_n, rd_n, wr_n are 1 -> IDLE.
//    Guarantees exactly one commit per strobe assertion regardless of its length.
//  Read latency with N=0: o_di valid at the edge after decode (one clock after strobe low).
//  o_di retains last read value outside read cycles (tv80 samples only in read T-states).
//  Preload: i_ld_en honoured only in IDLE with no bus strobe active; otherwise ignored.
//   Preload writes mem[i_ld_addr[MEM_AW-1:0]]=i_ld_data on that edge. Same-edge preload and
//   bus decode: bus wins, preload dropped.
//  Addresses beyond 2**MEM_AW wrap (upper bits ignored).
// TESTING
//  1 preload mem[0]=8'h04, release reset, WAIT_STATES=0 -> M1 fetch returns 8'h04, o_wait_n never 0,
//    tv80 executes INC B with B=8'hff -> B=8'h00, F=8'h50, PC=16'h0001.
//  2 WAIT_STATES=3, MRD at 16'h1234 holding 8'hA5 -> o_wait_n low exactly 3 cycles, then
//    o_di=8'hA5; strobe held 5 extra cycles -> no re-access, o_busy until strobes release.
//  3 MWR 16'h8000 <- 8'h3C held 4 cycles, then MRD 16'h8000 -> single commit, reads 8'h3C.
//  4 INTA with i_int_vector=8'hFF, INTA_WAITS=2 -> 2 wait cycles, o_di=8'hFF; OUT (8'h10),8'h55
//    -> one o_io_wr pulse, o_io_addr=8'h10, o_io_data=8'h55.
//  5 refresh cycle at 16'h0000 -> no wait, mem unchanged; i_reset_n low during WAIT of an MWR
//    -> o_wait_n=1 immediately, target byte unchanged, FSM IDLE after release.
//  6 i_ld_en asserted during HOLD -> ignored (mem unchanged); asserted in IDLE -> written.

Source files
------------

// File: rtl/z80_bus_responder.sv
// Z80 bus target: byte memory, IO and INTA responder with programmable wait states.
// Reads return data one clock after decode plus N wait cycles; exactly one commit per strobe assertion.
module z80_bus_responder #(
   parameter int MEM_AW      = 16,
   parameter int WAIT_STATES = 0,
   parameter int INTA_WAITS  = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [15:0] i_a,
   input  logic [7:0]  i_do,
   input  logic        i_mreq_n,
   input  logic        i_iorq_n,
   input  logic        i_rd_n,
   input  logic        i_wr_n,
   input  logic        i_m1_n,
   input  logic        i_rfsh_n,
   output logic [7:0]  o_di,
   output logic        o_wait_n,
   input  logic [7:0]  i_io_rdata,
   input  logic [7:0]  i_int_vector,
   output logic        o_io_wr,
   output logic [7:0]  o_io_addr,
   output logic [7:0]  o_io_data,
   input  logic        i_ld_en,
   input  logic [15:0] i_ld_addr,
   input  logic [7:0]  i_ld_data,
   output logic        o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
   typedef enum logic [2:0] {C_MRD, C_MWR, C_IORD, C_IOWR, C_INTA} cyc_t;

   state_t      state;
   cyc_t        cyc;
   cyc_t        dec_cyc;
   logic [3:0]  cnt;
   logic [3:0]  n_waits;
   logic [15:0] a_q;
   logic [7:0]  wdat_q;
   logic [7:0]  mem [0:(1<<MEM_AW)-1];

   logic mrd, mwr, iord, iowr, inta, any_cyc, strobe_act, cyc_live;
   logic mem_we, ld_ok;

   assign mrd        = !i_mreq_n & !i_rd_n & i_rfsh_n;
   assign mwr        = !i_mreq_n & !i_wr_n & i_rfsh_n;
   assign iord       = !i_iorq_n & !i_rd_n & i_m1_n;
   assign iowr       = !i_iorq_n & !i_wr_n & i_m1_n;
   assign inta       = !i_iorq_n & !i_m1_n;
   assign any_cyc    = inta | mwr | mrd | iowr | iord;
   assign strobe_act = !i_mreq_n | !i_iorq_n | !i_rd_n | !i_wr_n;

   always_comb begin
      dec_cyc = C_IORD;
      if (inta)      dec_cyc = C_INTA;
      else if (mwr)  dec_cyc = C_MWR;
      else if (mrd)  dec_cyc = C_MRD;
      else if (iowr) dec_cyc = C_IOWR;
   end

   assign n_waits = (dec_cyc == C_INTA) ? 4'(INTA_WAITS) : 4'(WAIT_STATES);

   // The cycle being stretched must still be asserted, otherwise the CPU abandoned it.
   always_comb begin
      cyc_live = 1'b0;
      case (cyc)
         C_MRD:   cyc_live = mrd;
         C_MWR:   cyc_live = mwr;
         C_IORD:  cyc_live = iord;
         C_IOWR:  cyc_live = iowr;
         C_INTA:  cyc_live = inta;
         default: cyc_live = 1'b0;
      endcase
   end

   assign mem_we = (state == S_ACCESS) && (cyc == C_MWR);
   assign ld_ok  = (state == S_IDLE) && !strobe_act && i_ld_en;
   assign o_busy = (state != S_IDLE);

   // Memory has no reset; preload is usable while the FSM is held in reset.
   always_ff @(posedge i_clk) begin
      if (mem_we)
         mem[a_q[MEM_AW-1:0]] <= wdat_q;
      else if (ld_ok)
         mem[i_ld_addr[MEM_AW-1:0]] <= i_ld_data;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= S_IDLE;
         cyc       <= C_MRD;
         cnt       <= 4'd0;
         a_q       <= 16'h0000;
         wdat_q    <= 8'h00;
         o_di      <= 8'h00;
         o_wait_n  <= 1'b1;
         o_io_wr   <= 1'b0;
         o_io_addr <= 8'h00;
         o_io_data <= 8'h00;
      end else begin
         o_io_wr <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_cyc) begin
                  cyc    <= dec_cyc;
                  a_q    <= i_a;
                  wdat_q <= i_do;
                  if (n_waits != 4'd0) begin
                     cnt      <= n_waits;
                     o_wait_n <= 1'b0;
                     state    <= S_WAIT;
                  end else begin
                     state <= S_ACCESS;
                  end
               end
            end
            S_WAIT: begin
               if (!cyc_live) begin
                  o_wait_n <= 1'b1;
                  state    <= S_IDLE;
               end else if (cnt == 4'd1) begin
                  o_wait_n <= 1'b1;
                  state    <= S_ACCESS;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_ACCESS: begin
               case (cyc)
                  C_MRD:  o_di <= mem[a_q[MEM_AW-1:0]];
                  C_IORD: o_di <= i_io_rdata;
                  C_INTA: o_di <= i_int_vector;
                  C_IOWR: begin
                     o_io_wr   <= 1'b1;
                     o_io_addr <= a_q[7:0];
                     o_io_data <= wdat_q;
                  end
                  default: ;
               endcase
               o_wait_n <= 1'b1;
               state    <= S_HOLD;
            end
            S_HOLD: begin
               if (!strobe_act)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: two instances (no waits / 3+2 waits with 12-bit memory) on one bus.
module tb_z80_bus_responder;

   localparam int K_MRD = 0, K_MWR = 1, K_IORD = 2, K_IOWR = 3, K_INTA = 4, K_RFSH = 5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] a;
   logic [7:0]  cpu_do;
   logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
   logic [7:0]  io_rdata, int_vector;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [7:0]  ld_data;

   logic [7:0]  di_a, di_b, io_addr_a, io_addr_b, io_data_a, io_data_b;
   logic        wait_n_a, wait_n_b, io_wr_a, io_wr_b, busy_a, busy_b;

   always #5 clk = ~clk;

   z80_bus_responder #(.MEM_AW(16), .WAIT_STATES(0), .INTA_WAITS(0)) ua (
      .i_clk(clk), .i_reset_n(reset_n), .i_a(a), .i_do(cpu_do),
      .i_mreq_n(mreq_n), .i_iorq_n(iorq_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
      .i_m1_n(m1_n), .i_rfsh_n(rfsh_n), .o_di(di_a), .o_wait_n(wait_n_a),
      .i_io_rdata(io_rdata), .i_int_vector(int_vector), .o_io_wr(io_wr_a),
      .o_io_addr(io_addr_a), .o_io_data(io_data_a), .i_ld_en(ld_en),
      .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_busy(busy_a));

   z80_bus_responder #(.MEM_AW(12), .WAIT_STATES(3), .INTA_WAITS(2)) ub (
      .i_clk(clk), .i_reset_n(reset_n), .i_a(a), .i_do(cpu_do),
      .i_mreq_n(mreq_n), .i_iorq_n(iorq_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
      .i_m1_n(m1_n), .i_rfsh_n(rfsh_n), .o_di(di_b), .o_wait_n(wait_n_b),
      .i_io_rdata(io_rdata), .i_int_vector(int_vector), .o_io_wr(io_wr_b),
      .o_io_addr(io_addr_b), .o_io_data(io_data_b), .i_ld_en(ld_en),
      .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_busy(busy_b));

   // Reference model: flat byte arrays per instance plus last-read and last-IO-write state.
   bit [7:0]    mem_a [65536];
   bit [7:0]    mem_b [4096];
   logic [7:0]  di_a_m, di_b_m, ioa_m, iod_m;
   logic [15:0] pool [8];
   int          n_chk = 0;
   int          n_pass = 0;

   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [7:0]  dat;
      logic [7:0]  iod;
      logic [7:0]  vec;
      logic [7:0]  exp_a;
      logic [7:0]  exp_b;
   } vec_t;
   vec_t tbl [10];

   function automatic int exp_waits(input int kind, input int ws, input int iw);
      if (kind == K_INTA) return iw;
      if (kind == K_RFSH) return 0;
      return ws;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic release_bus();
      mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
   endtask

   task automatic set_bus(input int kind, input logic [15:0] addr, input logic [7:0] dat);
      release_bus();
      a = addr;
      cpu_do = dat;
      case (kind)
         K_MRD:   begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'($urandom_range(0, 1)); end
         K_MWR:   begin mreq_n = 1'b0; wr_n = 1'b0; end
         K_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
         K_IOWR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
         K_INTA:  begin iorq_n = 1'b0; m1_n = 1'b0; end
         default: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
      endcase
   endtask

   task automatic preload(input logic [15:0] addr, input logic [7:0] dat);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = addr; ld_data = dat;
      @(negedge clk);
      ld_en = 1'b0;
      mem_a[addr] = dat;
      mem_b[addr[11:0]] = dat;
   endtask

   task automatic check_reset_state();
      check("rst_di_a", 32'(di_a), 0);         check("rst_di_b", 32'(di_b), 0);
      check("rst_wait_a", 32'(wait_n_a), 1);   check("rst_wait_b", 32'(wait_n_b), 1);
      check("rst_iowr_a", 32'(io_wr_a), 0);    check("rst_iowr_b", 32'(io_wr_b), 0);
      check("rst_ioaddr_a", 32'(io_addr_a), 0); check("rst_ioaddr_b", 32'(io_addr_b), 0);
      check("rst_iodata_a", 32'(io_data_a), 0); check("rst_iodata_b", 32'(io_data_b), 0);
      check("rst_busy_a", 32'(busy_a), 0);     check("rst_busy_b", 32'(busy_b), 0);
   endtask

   // One complete bus cycle held for 'hold' clocks, then released; checks every observable.
   task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] dat,
                            input int hold, input logic [7:0] exp_a, input logic [7:0] exp_b);
      int wa, wb, pa, pb;
      wa = 0; wb = 0; pa = 0; pb = 0;
      @(negedge clk);
      set_bus(kind, addr, dat);
      repeat (hold) begin
         @(negedge clk);
         if (!wait_n_a) wa++;
         if (!wait_n_b) wb++;
         if (io_wr_a) pa++;
         if (io_wr_b) pb++;
      end
      check("busy_held_a", 32'(busy_a), 32'(kind != K_RFSH));
      check("busy_held_b", 32'(busy_b), 32'(kind != K_RFSH));
      release_bus();
      repeat (2) begin
         @(negedge clk);
         if (io_wr_a) pa++;
         if (io_wr_b) pb++;
      end
      if (kind == K_MWR) begin
         mem_a[addr] = dat;
         mem_b[addr[11:0]] = dat;
      end
      if (kind == K_IOWR) begin
         ioa_m = addr[7:0];
         iod_m = dat;
      end
      di_a_m = exp_a;
      di_b_m = exp_b;
      check("waits_a", 32'(wa), exp_waits(kind, 0, 0));
      check("waits_b", 32'(wb), exp_waits(kind, 3, 2));
      check("di_a", 32'(di_a), 32'(exp_a));
      check("di_b", 32'(di_b), 32'(exp_b));
      check("iowr_pulses_a", 32'(pa), 32'(kind == K_IOWR));
      check("iowr_pulses_b", 32'(pb), 32'(kind == K_IOWR));
      check("io_addr_a", 32'(io_addr_a), 32'(ioa_m));
      check("io_addr_b", 32'(io_addr_b), 32'(ioa_m));
      check("io_data_a", 32'(io_data_a), 32'(iod_m));
      check("io_data_b", 32'(io_data_b), 32'(iod_m));
      check("busy_released_a", 32'(busy_a), 0);
      check("busy_released_b", 32'(busy_b), 0);
      check("wait_idle_b", 32'(wait_n_b), 1);
   endtask

   initial begin
      logic [15:0] p;
      logic [7:0]  oldv, newv;

      reset_n = 1'b0;
      release_bus();
      a = 16'h0000; cpu_do = 8'h00; io_rdata = 8'h00; int_vector = 8'h00;
      ld_en = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
      di_a_m = 8'h00; di_b_m = 8'h00; ioa_m = 8'h00; iod_m = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_state();

      // Preload while the responder is held in reset.
      preload(16'h0000, 8'h04);
      preload(16'h1234, 8'hA5);
      for (int i = 0; i < 4; i++) begin
         pool[i]     = 16'($urandom);
         pool[i + 4] = pool[i] ^ {4'($urandom_range(1, 15)), 12'h000};
      end
      for (int i = 0; i < 8; i++) preload(pool[i], 8'($urandom));
      @(negedge clk);
      reset_n = 1'b1;

      tbl[0] = '{K_MRD,  16'h0000, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04};
      tbl[1] = '{K_MRD,  16'h1234, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5};
      tbl[2] = '{K_MWR,  16'h8000, 8'h3C, 8'h00, 8'h00, 8'hA5, 8'hA5};
      tbl[3] = '{K_MRD,  16'h8000, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C};
      tbl[4] = '{K_MRD,  16'h0000, 8'h00, 8'h00, 8'h00, 8'h04, 8'h3C};
      tbl[5] = '{K_INTA, 16'h0000, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
      tbl[6] = '{K_IOWR, 16'h5510, 8'h55, 8'h00, 8'h00, 8'hFF, 8'hFF};
      tbl[7] = '{K_IORD, 16'h0020, 8'h00, 8'h9E, 8'h00, 8'h9E, 8'h9E};
      tbl[8] = '{K_RFSH, 16'h0000, 8'h77, 8'h00, 8'h00, 8'h9E, 8'h9E};
      tbl[9] = '{K_MRD,  16'h0000, 8'h00, 8'h00, 8'h00, 8'h04, 8'h3C};
      for (int i = 0; i < 10; i++) begin
         io_rdata = tbl[i].iod;
         int_vector = tbl[i].vec;
         bus_cycle(tbl[i].kind, tbl[i].addr, tbl[i].dat, 7, tbl[i].exp_a, tbl[i].exp_b);
      end

      for (int t = 0; t < 60; t++) begin
         int          k;
         logic [15:0] ad;
         logic [7:0]  ea, eb;
         k = $urandom_range(0, 5);
         ad = (k == K_IORD || k == K_IOWR || k == K_INTA) ? 16'($urandom) : pool[$urandom_range(0, 7)];
         io_rdata = 8'($urandom);
         int_vector = 8'($urandom);
         ea = di_a_m; eb = di_b_m;
         case (k)
            K_MRD:  begin ea = mem_a[ad]; eb = mem_b[ad[11:0]]; end
            K_IORD: begin ea = io_rdata; eb = io_rdata; end
            K_INTA: begin ea = int_vector; eb = int_vector; end
            default: ;
         endcase
         bus_cycle(k, ad, 8'($urandom), 6 + $urandom_range(0, 3), ea, eb);
      end

      // Preload asserted while both instances sit in HOLD: must be ignored.
      p = pool[0];
      oldv = mem_a[p];
      @(negedge clk);
      set_bus(K_MRD, p, 8'h00);
      repeat (7) @(negedge clk);
      ld_en = 1'b1; ld_addr = p; ld_data = ~oldv;
      @(negedge clk);
      ld_en = 1'b0;
      release_bus();
      repeat (2) @(negedge clk);
      bus_cycle(K_MRD, p, 8'h00, 6, oldv, mem_b[p[11:0]]);

      // Preload on the same edge as a bus decode: bus wins, preload dropped.
      @(negedge clk);
      set_bus(K_MRD, p, 8'h00);
      ld_en = 1'b1; ld_addr = p; ld_data = ~oldv;
      @(negedge clk);
      ld_en = 1'b0;
      repeat (6) @(negedge clk);
      release_bus();
      repeat (2) @(negedge clk);
      bus_cycle(K_MRD, p, 8'h00, 6, oldv, mem_b[p[11:0]]);

      // Preload in IDLE takes effect.
      preload(p, ~oldv);
      bus_cycle(K_MRD, p, 8'h00, 6, mem_a[p], mem_b[p[11:0]]);

      // Reset during the wait phase of a write: slow instance must not commit.
      p = pool[1];
      newv = ~mem_b[p[11:0]];
      @(negedge clk);
      set_bus(K_MWR, p, newv);
      repeat (2) @(negedge clk);
      check("midrst_in_wait_b", 32'(wait_n_b), 0);
      reset_n = 1'b0;
      #1;
      check("midrst_wait_b", 32'(wait_n_b), 1);
      check("midrst_busy_b", 32'(busy_b), 0);
      check("midrst_di_b", 32'(di_b), 0);
      mem_a[p] = newv;
      di_a_m = 8'h00; di_b_m = 8'h00; ioa_m = 8'h00; iod_m = 8'h00;
      release_bus();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("postrst_busy_b", 32'(busy_b), 0);
      check("postrst_io_addr_a", 32'(io_addr_a), 0);
      bus_cycle(K_MRD, p, 8'h00, 6, mem_a[p], mem_b[p[11:0]]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
